// File: rtl/bcnt_pkg.sv
// bcnt_pkg: op and FSM state encodings shared by the bit-count unit.
package bcnt_pkg;

  // Op code is {clz,ctz} as presented on the request.
  typedef enum logic [1:0] {
    OP_POP  = 2'b00,
    OP_CTZ  = 2'b01,
    OP_CLZ  = 2'b10,
    OP_ZCNT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcnt_if.sv
// bcnt_if: request/response handshake bundle for bcnt_seq.
// master = requester/consumer side, slave = bit-count unit.
interface bcnt_if #(parameter int ORDER = 5);
  localparam int W = 1 << ORDER;

  logic             in_valid;
  logic             in_ready;
  logic             clz;
  logic             ctz;
  logic [W-1:0]     in;
  logic             out_valid;
  logic             out_ready;
  logic [ORDER:0]   out;
  logic             zero;

  modport master (
    output in_valid, clz, ctz, in, out_ready,
    input  in_ready, out_valid, out, zero
  );

  modport slave (
    input  in_valid, clz, ctz, in, out_ready,
    output in_ready, out_valid, out, zero
  );
endinterface

// File: rtl/bcnt_chunk.sv
// bcnt_chunk: combinational count over one 2^CHUNK-bit chunk.
// CLZ/CTZ give leading/trailing zeros in the chunk; every other op
// gives the number of zero bits (popcount is pre-inverted upstream).
module bcnt_chunk
  import bcnt_pkg::*;
#(
  parameter int CHUNK = 3
) (
  input  logic [(1<<CHUNK)-1:0] chunk,
  input  op_e                   op,
  output logic [CHUNK:0]        cnt,
  output logic                  allz
);
  localparam int C = 1 << CHUNK;
  localparam logic [CHUNK:0] ONE = 1;

  logic run;

  // Walk the chunk in the op's direction; run drops at the first one.
  always_comb begin
    cnt  = '0;
    run  = 1'b1;
    allz = ~|chunk;
    case (op)
      OP_CLZ:
        for (int i = C - 1; i >= 0; i--) begin
          if (chunk[i]) run = 1'b0;
          if (run) cnt = cnt + ONE;
        end
      OP_CTZ:
        for (int i = 0; i < C; i++) begin
          if (chunk[i]) run = 1'b0;
          if (run) cnt = cnt + ONE;
        end
      default:
        for (int i = 0; i < C; i++)
          if (!chunk[i]) cnt = cnt + ONE;
    endcase
  end
endmodule

// File: rtl/bcnt_seq.sv
// bcnt_seq: multi-cycle bit counter, one chunk per clock.
// Build options:
//   BCNT_EARLY_EXIT_EN - clz/ctz stop at the first non-zero chunk;
//                        otherwise every op takes N scan cycles.
//   BCNT_POPCOUNT_EN   - op 00 counts ones; otherwise op 00 == zerocount.
module bcnt_seq
  import bcnt_pkg::*;
#(
  parameter int ORDER = 5,
  parameter int CHUNK = 3
) (
  input  logic    clk,
  input  logic    reset,
  bcnt_if.slave   b
);
  localparam int W  = 1 << ORDER;
  localparam int C  = 1 << CHUNK;
  localparam int N  = 1 << (ORDER - CHUNK);
  localparam int IW = (ORDER > CHUNK) ? (ORDER - CHUNK) : 1;
  localparam int AW = ORDER + 1;
  localparam logic [IW-1:0] ONE_I = 1;

  state_e          state, nstate;
  op_e             op, in_op;
  logic [W-1:0]    word, in_word;
  logic [IW-1:0]   idx, step;
  logic [AW-1:0]   acc, acc_nxt, out_r;
  logic            zero_r;
  logic [C-1:0]    chunk;
  logic [CHUNK:0]  cnt, addv;
  logic            allz, is_tz, fin;

  assign chunk = word[idx*C +: C];
  assign is_tz = (op == OP_CLZ) || (op == OP_CTZ);

  bcnt_chunk #(.CHUNK(CHUNK)) u_chunk (
    .chunk (chunk),
    .op    (op),
    .cnt   (cnt),
    .allz  (allz)
  );

`ifdef BCNT_EARLY_EXIT_EN
  assign fin  = (step == IW'(N - 1)) || (is_tz && !allz);
  assign addv = cnt;
`else
  // Sticky: after the first non-zero chunk, clz/ctz stop accumulating.
  logic hit;
  assign fin  = (step == IW'(N - 1));
  assign addv = hit ? '0 : cnt;
`endif

  assign acc_nxt = acc + AW'(addv);

  // Normalise the op at latch time so the scan only sees CLZ/CTZ/ZCNT.
  always_comb begin
    in_op   = op_e'({b.clz, b.ctz});
    in_word = b.in;
    if (in_op == OP_POP) begin
`ifdef BCNT_POPCOUNT_EN
      in_word = ~b.in;
`endif
      in_op = OP_ZCNT;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  // Next state and handshake outputs.
  always_comb begin
    nstate      = state;
    b.in_ready  = 1'b0;
    b.out_valid = 1'b0;
    case (state)
      IDLE: begin
        b.in_ready = 1'b1;
        if (b.in_valid) nstate = SCAN;
      end
      SCAN: if (fin) nstate = DONE;
      DONE: begin
        b.out_valid = 1'b1;
        if (b.out_ready) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Datapath: latch request, accumulate per chunk, register result.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      out_r  <= '0;
      zero_r <= 1'b0;
      word   <= '0;
      op     <= OP_ZCNT;
      idx    <= '0;
      step   <= '0;
`ifndef BCNT_EARLY_EXIT_EN
      hit    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (b.in_valid) begin
          word <= in_word;
          op   <= in_op;
          acc  <= '0;
          step <= '0;
          idx  <= (in_op == OP_CLZ) ? IW'(N - 1) : '0;
`ifndef BCNT_EARLY_EXIT_EN
          hit  <= 1'b0;
`endif
        end
        SCAN: begin
          acc <= acc_nxt;
`ifndef BCNT_EARLY_EXIT_EN
          if (is_tz && !allz) hit <= 1'b1;
`endif
          if (fin) begin
            out_r  <= acc_nxt;
            zero_r <= (acc_nxt == AW'(W));
          end else begin
            step <= step + ONE_I;
            idx  <= (op == OP_CLZ) ? idx - ONE_I : idx + ONE_I;
          end
        end
        default: ;
      endcase
    end
  end

  assign b.out  = out_r;
  assign b.zero = zero_r;
endmodule

// File: tb/tb_bcnt_seq.sv
// tb_bcnt_seq: scoreboard bench for bcnt_seq (directed + random).
module tb_bcnt_seq;
  localparam int ORDER = 5;
  localparam int CHUNK = 3;
  localparam int W = 1 << ORDER;
  localparam int C = 1 << CHUNK;
  localparam int N = W / C;

  typedef struct {
    int       cnt;
    bit       zero;
    int       vcyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   started = 1'b0;
  bit   hold_valid = 1'b0;
  int   bp_req = 0;
  exp_t q[$];

  bcnt_if #(.ORDER(ORDER)) b ();

  bcnt_seq #(.ORDER(ORDER), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .reset (reset),
    .b     (b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: count straight from the op definitions over the whole word.
  function automatic int ref_cnt(input logic [1:0] op, input logic [W-1:0] w);
    int n = 0;
    int i;
    case (op)
      2'b10: begin i = W - 1; while (i >= 0 && !w[i]) begin n++; i--; end end
      2'b01: begin i = 0;     while (i < W && !w[i])  begin n++; i++; end end
`ifdef BCNT_POPCOUNT_EN
      2'b00: n = $countones(w);
`endif
      default: n = W - $countones(w);
    endcase
    return n;
  endfunction

  // Scan length: clz/ctz stop at the chunk holding the first one.
  function automatic int ref_k(input logic [1:0] op, input int n);
`ifdef BCNT_EARLY_EXIT_EN
    if (op == 2'b10 || op == 2'b01) return (n / C + 1 > N) ? N : n / C + 1;
`endif
    return N;
  endfunction

  task automatic send(input logic [1:0] op, input logic [W-1:0] w, input bit push);
    int   g = 0;
    int   n, k;
    exp_t e;
    @(negedge clk);
    while (b.in_ready !== 1'b1 && g < 300) begin
      b.in_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
      b.in = $urandom;
      {b.clz, b.ctz} = 2'($urandom);
      g++;
      @(negedge clk);
    end
    if (g >= 300) begin
      chk(1'b0, "accept_timeout", g, 300);
      return;
    end
    b.in_valid = 1'b1;
    {b.clz, b.ctz} = op;
    b.in = w;
    if (push) begin
      n = ref_cnt(op, w);
      k = ref_k(op, n);
      e.cnt  = n;
      e.zero = (n == W);
      e.vcyc = cyc + k + 1;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b.in_valid = (b.in_ready === 1'b1) ? 1'b0 : 1'($urandom_range(0, 1));
      b.in = $urandom;
    end
  endtask

  // Monitor: pops on the first DONE cycle, then checks hold/backpressure.
  initial begin
    bit   seen = 1'b0;
    bit   hand = 1'b0;
    int   bpc = 0;
    exp_t cur;
    b.out_ready = 1'b0;
    wait (started);
    forever begin
      @(negedge clk);
      if (hand) begin
        chk(b.in_ready === 1'b1, "handoff_in_ready", b.in_ready, 1);
        chk(b.out_valid === 1'b0, "handoff_out_valid", b.out_valid, 0);
        hand = 1'b0;
      end
      if (reset) begin
        seen = 1'b0;
        b.out_ready = 1'b0;
        continue;
      end
      if (b.out_valid === 1'b1) begin
        if (!seen) begin
          if (q.size() == 0) begin
            chk(1'b0, "unexpected_result", b.out, -1);
            b.out_ready = 1'b1;
            continue;
          end
          cur = q.pop_front();
          chk(b.out == cur.cnt, "out", b.out, cur.cnt);
          chk(b.zero == cur.zero, "zero", b.zero, cur.zero);
          chk(cyc == cur.vcyc, "latency", cyc, cur.vcyc);
          seen = 1'b1;
          bpc = bp_req;
          bp_req = 0;
        end else begin
          chk(b.out == cur.cnt, "hold_out", b.out, cur.cnt);
          chk(b.zero == cur.zero, "hold_zero", b.zero, cur.zero);
          chk(b.in_ready === 1'b0, "done_in_ready", b.in_ready, 0);
        end
        if (bpc > 0) begin
          b.out_ready = 1'b0;
          bpc--;
        end else begin
          b.out_ready = ($urandom_range(0, 3) != 0);
        end
        if (b.out_ready) begin
          seen = 1'b0;
          hand = 1'b1;
        end
      end else begin
        b.out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got cycle %0d want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    logic [W-1:0] w;
    logic [1:0]   op;
    int           g;
    b.in_valid = 1'b0;
    b.in = '0;
    b.clz = 1'b0;
    b.ctz = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk(b.in_ready === 1'b1, "rst_in_ready", b.in_ready, 1);
    chk(b.out_valid === 1'b0, "rst_out_valid", b.out_valid, 0);
    chk(b.out === '0, "rst_out", b.out, 0);
    chk(b.zero === 1'b0, "rst_zero", b.zero, 0);
    reset = 1'b0;
    started = 1'b1;

    send(2'b10, 32'h0000_1234, 1'b1);
    send(2'b01, 32'h0000_0000, 1'b1);
    send(2'b01, 32'h0001_0000, 1'b1);
    send(2'b11, 32'hF0F0_F0F0, 1'b1);
    send(2'b11, 32'hFFFF_FFFF, 1'b1);
    send(2'b00, 32'hFFFF_FFFF, 1'b1);
    send(2'b00, 32'h0000_0000, 1'b1);
    send(2'b10, 32'h0000_0000, 1'b1);

    // Backpressure with in_valid held high across DONE.
    hold_valid = 1'b1;
    bp_req = 5;
    send(2'b10, 32'h00FF_0000, 1'b1);
    send(2'b01, 32'h0000_0100, 1'b1);
    hold_valid = 1'b0;

    // Reset in the second SCAN cycle drops the request.
    send(2'b10, 32'h0000_1234, 1'b0);
    @(negedge clk);
    b.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk(b.out_valid === 1'b0, "scanrst_out_valid", b.out_valid, 0);
    chk(b.in_ready === 1'b1, "scanrst_in_ready", b.in_ready, 1);
    chk(b.out === '0, "scanrst_out", b.out, 0);
    reset = 1'b0;
    send(2'b10, 32'h8000_0000, 1'b1);

    for (int t = 0; t < 60; t++) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: w = w >> $urandom_range(0, W - 1);
        2: w = w << $urandom_range(0, W - 1);
        default: w = ($urandom_range(0, 1) != 0) ? '0 : (32'h1 << $urandom_range(0, W - 1));
      endcase
      op = 2'($urandom);
      send(op, w, 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    @(negedge clk);
    b.in_valid = 1'b0;
    g = 0;
    while ((q.size() != 0 || b.out_valid === 1'b1) && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk(g < 500, "drain_timeout", g, 500);
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
